// File: rtl/compute_t_pkg.sv
// rtl/compute_t_pkg.sv - shared IDCT constants: FSM encodings, widths and the C coefficient table
package compute_t_pkg;

  localparam int CT_ACC_W   = 40;
  localparam int CT_T_SHIFT = 8;

  typedef logic [1:0] ct_state_t;

  localparam ct_state_t S_CT_IDLE  = 2'd0;
  localparam ct_state_t S_CT_RUN   = 2'd1;
  localparam ct_state_t S_CT_FLUSH = 2'd2;
  localparam ct_state_t S_CT_DONE  = 2'd3;

  // DCT basis scaled by 4096/sqrt(8); row index is the frequency k, column index the sample c
  localparam logic signed [15:0] IDCT_C [0:7][0:7] = '{
    '{ 16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448},
    '{ 16'sd2008,  16'sd1702,  16'sd1137,  16'sd399,  -16'sd399,  -16'sd1137, -16'sd1702, -16'sd2008},
    '{ 16'sd1892,  16'sd783,  -16'sd783,  -16'sd1892, -16'sd1892, -16'sd783,   16'sd783,   16'sd1892},
    '{ 16'sd1702, -16'sd399,  -16'sd2008, -16'sd1137,  16'sd1137,  16'sd2008,  16'sd399,  -16'sd1702},
    '{ 16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448},
    '{ 16'sd1137, -16'sd2008,  16'sd399,   16'sd1702, -16'sd1702, -16'sd399,   16'sd2008, -16'sd1137},
    '{ 16'sd783,  -16'sd1892,  16'sd1892, -16'sd783,  -16'sd783,   16'sd1892, -16'sd1892,  16'sd783},
    '{ 16'sd399,  -16'sd1137,  16'sd1702, -16'sd2008,  16'sd2008, -16'sd1702,  16'sd1137, -16'sd399}
  };

  function automatic logic signed [15:0] idct_coef(input logic [2:0] k, input logic [2:0] c);
    return IDCT_C[k][c];
  endfunction

endpackage

// File: rtl/idct_c_rom.sv
// rtl/idct_c_rom.sv - combinational lookup of C[k][c]
module idct_c_rom
  import compute_t_pkg::*;
(
  input  logic        [2:0]  k_i,
  input  logic        [2:0]  c_i,
  output logic signed [15:0] coef_o
);

  assign coef_o = idct_coef(k_i, c_i);

endmodule

// File: rtl/compute_t.sv
// rtl/compute_t.sv - computes T = S' x C for one 8x8 block, S' from DPRAM0, T to DPRAM1
// Two-stage pipe: address issue, then multiply-accumulate with a registered write on the 8th term.
module compute_t
  import compute_t_pkg::*;
#(
  parameter int ACC_W   = CT_ACC_W,
  parameter int T_SHIFT = CT_T_SHIFT
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        CT_start,
  output logic        CT_done,
  output logic [6:0]  CT_read_address,
  input  logic [31:0] CT_read_data,
  output logic [5:0]  CT_write_address,
  output logic [31:0] CT_write_data,
  output logic        CT_write_enable
);

  ct_state_t state_q, state_d;
  logic [8:0]  idx_q, idx_d;            // {r, c, k} of the address being issued
  logic        flush_q, flush_d;
  logic        pipe_vld_q, pipe_vld_d;
  logic [8:0]  pipe_idx_q, pipe_idx_d;  // {r, c, k} of the data arriving this cycle
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        we_q, we_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic signed [15:0]      s_val;
  logic signed [15:0]      coef;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_sh;
  logic                    unused_bits;

  idct_c_rom u_c_rom (
    .k_i    (pipe_idx_q[2:0]),
    .c_i    (pipe_idx_q[5:3]),
    .coef_o (coef)
  );

  assign s_val    = CT_read_data[15:0];
  assign prod     = s_val * coef;
  assign prod_ext = ACC_W'(prod);
  assign acc_base = (pipe_idx_q[2:0] == 3'd0) ? '0 : acc_q;
  assign sum      = acc_base + prod_ext;
  assign sum_sh   = sum >>> T_SHIFT;

  assign unused_bits = ^{CT_read_data[31:16], sum_sh[ACC_W-1:32]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    flush_d    = flush_q;
    pipe_vld_d = 1'b0;
    pipe_idx_d = pipe_idx_q;
    acc_d      = acc_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_CT_IDLE: begin
        if (CT_start) state_d = S_CT_RUN;
      end
      S_CT_RUN: begin
        pipe_vld_d = 1'b1;
        pipe_idx_d = idx_q;
        idx_d      = idx_q + 9'd1;
        flush_d    = 1'b0;
        if (idx_q == 9'd511) state_d = S_CT_FLUSH;
      end
      S_CT_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = S_CT_DONE;
      end
      default: begin
        state_d = S_CT_IDLE;
      end
    endcase

    if (pipe_vld_q) begin
      acc_d = sum;
      if (pipe_idx_q[2:0] == 3'd7) begin
        we_d    = 1'b1;
        waddr_d = pipe_idx_q[8:3];
        wdata_d = sum_sh[31:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      state_q    <= S_CT_IDLE;
      idx_q      <= '0;
      flush_q    <= 1'b0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      acc_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      flush_q    <= flush_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
      acc_q      <= acc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Row r of S' lives at {1, r, k}; the column counter does not affect the read address
  assign CT_read_address  = {1'b1, idx_q[8:6], idx_q[2:0]};
  assign CT_done          = (state_q == S_CT_DONE);
  assign CT_write_enable  = we_q;
  assign CT_write_address = waddr_q;
  assign CT_write_data    = wdata_q;

endmodule

// File: tb/tb_compute_t.sv
// tb/tb_compute_t.sv - randomized self-checking bench for compute_t against a matrix-product model
module tb_compute_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        done;
  logic [6:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        we;

  always #10 clk = ~clk;

  compute_t dut (
    .CLOCK_50_I       (clk),
    .Resetn           (resetn),
    .CT_start         (start),
    .CT_done          (done),
    .CT_read_address  (raddr),
    .CT_read_data     (rdata),
    .CT_write_address (waddr),
    .CT_write_data    (wdata),
    .CT_write_enable  (we)
  );

  int C [0:7][0:7] = '{
    '{1448, 1448, 1448, 1448, 1448, 1448, 1448, 1448},
    '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008},
    '{1892, 783, -783, -1892, -1892, -783, 783, 1892},
    '{1702, -399, -2008, -1137, 1137, 2008, 399, -1702},
    '{1448, -1448, -1448, 1448, 1448, -1448, -1448, 1448},
    '{1137, -2008, 399, 1702, -1702, -399, 2008, -1137},
    '{783, -1892, 1892, -783, -783, 1892, -1892, 783},
    '{399, -1137, 1702, -2008, 2008, -1702, 1137, -399}
  };

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] s_mem [0:127];
  int          s_ref [0:63];
  logic [31:0] t_ref [0:63];
  int          wr_cyc_q [$];
  logic [5:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          done_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdata <= s_mem[raddr];

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
    end
    if (done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle=%0d required<60000", cyc);
    $fatal(1);
  end

  function automatic void build_ref();
    longint sum;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        sum = 0;
        for (int k = 0; k < 8; k++) sum += longint'(s_ref[r*8+k]) * longint'(C[k][c]);
        t_ref[r*8+c] = 32'(sum >>> 8);
      end
  endfunction

  task automatic load_s(input int mode);
    logic [31:0] junk;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0: s_ref[i] = 0;
        1: s_ref[i] = (i == 0) ? 256 : 0;
        2: s_ref[i] = (i == 0) ? -256 : 0;
        3: s_ref[i] = 32767;
        4: s_ref[i] = int'($urandom_range(0, 65535)) - 32768;
        default: s_ref[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      endcase
      junk = $urandom();
      s_mem[i] = $urandom();
      s_mem[64+i] = {junk[31:16], 16'(s_ref[i])};
    end
    build_ref();
  endtask

  task automatic clear_q();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_q.delete();
  endtask

  task automatic start_block(output int base);
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_block(input int base, input string tag);
    int       rel;
    int       rd_err;
    bit       got;
    int       nw;
    logic [6:0] exp_ra;
    rd_err = 0;
    got    = 1'b0;
    for (int n = 0; n < 800 && !got; n++) begin
      rel    = cyc - base;
      exp_ra = (rel >= 0 && rel < 512) ? 7'(64 + (rel / 64) * 8 + rel % 8) : 7'd64;
      if (raddr !== exp_ra) rd_err++;
      if (done_q.size() > 0) got = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_timeout: no CT_done within 800 cycles, required done at cycle 514", tag);
    end else begin
      n_checks++;
      if (done_q[0] - base !== 514) begin
        n_fail++;
        $display("FAIL %s done_cycle: got %0d required 514", tag, done_q[0] - base);
      end
    end
    n_checks++;
    if (done_q.size() !== 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d required 1", tag, done_q.size());
    end
    n_checks++;
    if (rd_err !== 0) begin
      n_fail++;
      $display("FAIL %s read_addr: %0d cycles with wrong address, required 0", tag, rd_err);
    end
    n_checks++;
    if (wr_cyc_q.size() !== 64) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required 64", tag, wr_cyc_q.size());
    end
    nw = (wr_cyc_q.size() < 64) ? wr_cyc_q.size() : 64;
    for (int j = 0; j < nw; j++) begin
      n_checks++;
      if (wr_cyc_q[j] - base !== 9 + 8 * j) begin
        n_fail++;
        $display("FAIL %s write_cycle[%0d]: got %0d required %0d", tag, j, wr_cyc_q[j] - base, 9 + 8 * j);
      end
      n_checks++;
      if (wr_addr_q[j] !== 6'(j)) begin
        n_fail++;
        $display("FAIL %s write_addr[%0d]: got %0d required %0d", tag, j, wr_addr_q[j], j);
      end
      n_checks++;
      if (wr_data_q[j] !== t_ref[j]) begin
        n_fail++;
        $display("FAIL %s T[%0d][%0d]: got %h required %h", tag, j / 8, j % 8, wr_data_q[j], t_ref[j]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (done !== 1'b0 || we !== 1'b0 || waddr !== 6'd0 || wdata !== 32'd0 || raddr !== 7'd64) begin
      n_fail++;
      $display("FAIL %s reset_outputs: got done=%b we=%b waddr=%0d wdata=%h raddr=%0d required 0 0 0 00000000 64",
               tag, done, we, waddr, wdata, raddr);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_block(input int mode, input string tag);
    int base;
    load_s(mode);
    clear_q();
    start_block(base);
    check_block(base, tag);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base;
    load_s(4);
    clear_q();
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 1;
    check_block(base, "held_first");
    clear_q();
    // Start still high: the done cycle must not start a block, the following idle cycle must
    fork
      check_block(base + 516, "held_second");
      begin
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    n_checks++;
    if (wr_cyc_q.size() !== 64 || done_q.size() !== 1) begin
      n_fail++;
      $display("FAIL held_no_extra_block: got writes=%0d dones=%0d required 64 1", wr_cyc_q.size(), done_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int base;
    load_s(4);
    clear_q();
    start_block(base);
    for (int n = 0; n < 400 && (cyc - base) < 200; n++) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    resetn = 1'b1;
    repeat (600) @(negedge clk);
    n_checks++;
    if (done_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d done pulses required 0", done_q.size());
    end
    test_block(5, "after_reset");
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < 128; i++) s_mem[i] = '0;
    test_reset();
    test_block(0, "zeros");
    test_block(1, "impulse_pos");
    test_block(2, "impulse_neg");
    test_block(3, "all_max");
    test_block(4, "random_a");
    test_block(4, "random_b");
    test_block(5, "extremes");
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
